// File: rtl/integer_execute_unit_if.sv
// Operand, result and handshake bundle between the decode/regread stage, the
// integer execute unit and writeback.
interface integer_execute_unit_if #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 5
);
   logic             in_valid;
   logic             in_ready;
   logic [XLEN-1:0]  rs1_reg_content;
   logic [XLEN-1:0]  rs2_reg_content;
   logic [XLEN-1:0]  i_type_integer_inst_imm_extend;
   logic [6:0]       inst_opcode_field;
   logic [2:0]       inst_funct3_field;
   logic [6:0]       inst_funct7_field;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [XLEN-1:0]  alu_result;
   logic [TAG_W-1:0] out_tag;
   logic             busy;

   modport master (
      output in_valid, rs1_reg_content, rs2_reg_content, i_type_integer_inst_imm_extend,
             inst_opcode_field, inst_funct3_field, inst_funct7_field, in_tag, out_ready,
      input  in_ready, out_valid, alu_result, out_tag, busy
   );

   modport slave (
      input  in_valid, rs1_reg_content, rs2_reg_content, i_type_integer_inst_imm_extend,
             inst_opcode_field, inst_funct3_field, inst_funct7_field, in_tag, out_ready,
      output in_ready, out_valid, alu_result, out_tag, busy
   );
endinterface

// File: rtl/integer_execute_unit.sv
// RV32I/RV64I integer execute unit with M extension: single-cycle base ALU and
// an iterative shift-add multiplier / restoring divider sharing one sequencer.
module integer_execute_unit #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 5
) (
   input logic                   clk,
   input logic                   rst,
   input logic                   flush,
   integer_execute_unit_if.slave bus
);
   localparam int SHAMT_W = $clog2(XLEN);
   localparam int CNT_W   = $clog2(XLEN + 1);
   localparam logic [6:0] OPC_R  = 7'b0110011;
   localparam logic [6:0] OPC_I  = 7'b0010011;
   localparam logic [6:0] F7_ALT = 7'b0100000;
   localparam logic [6:0] F7_M   = 7'b0000001;
   localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t           state;
   logic [CNT_W-1:0] count;
   logic [XLEN-1:0]  acc_hi;
   logic [XLEN-1:0]  acc_lo;
   logic [XLEN-1:0]  opb;
   logic             is_div_q;
   logic             neg_prod_q;
   logic             neg_rem_q;
   logic [2:0]       funct3_q;
   logic [TAG_W-1:0] tag_q;

   logic              is_r, is_i, is_m, is_div, accept;
   logic [XLEN-1:0]   op1, op2;
   logic [SHAMT_W-1:0] shamt;
   logic [XLEN-1:0]   base_result, fast_result, quick_result;
   logic              a_signed, b_signed, a_neg, b_neg;
   logic [XLEN-1:0]   mag_a, mag_b;
   logic              div_zero, div_ovf, fast_hit;

   assign bus.in_ready = (state == IDLE) || (state == DONE && bus.out_ready);
   assign accept       = bus.in_valid && bus.in_ready;

   always_comb begin
      is_r   = bus.inst_opcode_field == OPC_R;
      is_i   = bus.inst_opcode_field == OPC_I;
      op1    = bus.rs1_reg_content;
      op2    = is_r ? bus.rs2_reg_content : bus.i_type_integer_inst_imm_extend;
      shamt  = op2[SHAMT_W-1:0];
      is_m   = is_r && bus.inst_funct7_field == F7_M;
      is_div = bus.inst_funct3_field[2];

      base_result = '0;
      if (is_r || is_i) begin
         case (bus.inst_funct3_field)
            3'b000:  base_result = (is_r && bus.inst_funct7_field == F7_ALT) ? op1 - op2 : op1 + op2;
            3'b001:  base_result = op1 << shamt;
            3'b010:  base_result = XLEN'($signed(op1) < $signed(op2));
            3'b011:  base_result = XLEN'(op1 < op2);
            3'b100:  base_result = op1 ^ op2;
            3'b101:  base_result = bus.inst_funct7_field[5] ? $unsigned($signed(op1) >>> shamt)
                                                            : op1 >> shamt;
            3'b110:  base_result = op1 | op2;
            default: base_result = op1 & op2;
         endcase
      end

      // MUL/MULH treat both operands as signed, MULHSU only rs1, MULHU neither.
      if (is_div) begin
         a_signed = !bus.inst_funct3_field[0];
         b_signed = !bus.inst_funct3_field[0];
      end else begin
         a_signed = bus.inst_funct3_field[1:0] != 2'b11;
         b_signed = !bus.inst_funct3_field[1];
      end
      a_neg = a_signed && bus.rs1_reg_content[XLEN-1];
      b_neg = b_signed && bus.rs2_reg_content[XLEN-1];
      mag_a = a_neg ? -bus.rs1_reg_content : bus.rs1_reg_content;
      mag_b = b_neg ? -bus.rs2_reg_content : bus.rs2_reg_content;

      div_zero = bus.rs2_reg_content == '0;
      div_ovf  = !bus.inst_funct3_field[0] && bus.rs1_reg_content == MOST_NEG
                 && bus.rs2_reg_content == '1;
      fast_hit = is_m && is_div && (div_zero || div_ovf);
      if (div_zero)
         fast_result = bus.inst_funct3_field[1] ? bus.rs1_reg_content : '1;
      else
         fast_result = bus.inst_funct3_field[1] ? '0 : bus.rs1_reg_content;

      quick_result = fast_hit ? fast_result : (is_m ? '0 : base_result);
   end

   logic [XLEN:0]     mul_sum, div_shift, div_diff;
   logic [XLEN-1:0]   step_hi, step_lo;
   logic [2*XLEN-1:0] prod, prod_fix;
   logic [XLEN-1:0]   quot_fix, rem_fix, final_result;

   // One iteration: multiply shifts the product right after a conditional add,
   // divide shifts the remainder left and keeps the subtract when it does not borrow.
   always_comb begin
      mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : '0);
      div_shift = {acc_hi, acc_lo[XLEN-1]};
      div_diff  = div_shift - {1'b0, opb};
      if (is_div_q) begin
         if (!div_diff[XLEN]) begin
            step_hi = div_diff[XLEN-1:0];
            step_lo = {acc_lo[XLEN-2:0], 1'b1};
         end else begin
            step_hi = div_shift[XLEN-1:0];
            step_lo = {acc_lo[XLEN-2:0], 1'b0};
         end
      end else begin
         step_hi = mul_sum[XLEN:1];
         step_lo = {mul_sum[0], acc_lo[XLEN-1:1]};
      end

      prod     = {step_hi, step_lo};
      prod_fix = neg_prod_q ? -prod : prod;
      quot_fix = neg_prod_q ? -step_lo : step_lo;
      rem_fix  = neg_rem_q ? -step_hi : step_hi;
      if (is_div_q)
         final_result = funct3_q[1] ? rem_fix : quot_fix;
      else
         final_result = (funct3_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         bus.out_valid  <= 1'b0;
         bus.busy       <= 1'b0;
         bus.alu_result <= '0;
         bus.out_tag    <= '0;
         count          <= '0;
         acc_hi         <= '0;
         acc_lo         <= '0;
         opb            <= '0;
         is_div_q       <= 1'b0;
         neg_prod_q     <= 1'b0;
         neg_rem_q      <= 1'b0;
         funct3_q       <= '0;
         tag_q          <= '0;
      end else if (flush) begin
         state         <= IDLE;
         bus.out_valid <= 1'b0;
         bus.busy      <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (state == DONE && bus.out_ready) begin
                  state         <= IDLE;
                  bus.out_valid <= 1'b0;
               end
               if (accept) begin
                  if (is_m && !fast_hit) begin
                     state         <= BUSY;
                     bus.busy      <= 1'b1;
                     bus.out_valid <= 1'b0;
                     count         <= CNT_W'(XLEN);
                     acc_hi        <= '0;
                     acc_lo        <= is_div ? mag_a : mag_b;
                     opb           <= is_div ? mag_b : mag_a;
                     is_div_q      <= is_div;
                     neg_prod_q    <= a_neg ^ b_neg;
                     neg_rem_q     <= a_neg;
                     funct3_q      <= bus.inst_funct3_field;
                     tag_q         <= bus.in_tag;
                  end else begin
                     state          <= DONE;
                     bus.out_valid  <= 1'b1;
                     bus.alu_result <= quick_result;
                     bus.out_tag    <= bus.in_tag;
                  end
               end
            end
            default: begin
               acc_hi <= step_hi;
               acc_lo <= step_lo;
               count  <= count - CNT_W'(1);
               if (count == CNT_W'(1)) begin
                  state          <= DONE;
                  bus.busy       <= 1'b0;
                  bus.out_valid  <= 1'b1;
                  bus.alu_result <= final_result;
                  bus.out_tag    <= tag_q;
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_integer_execute_unit.sv
// Directed-vector bench for integer_execute_unit at XLEN=32 with hand-computed results.
module tb_integer_execute_unit;
   localparam int XLEN  = 32;
   localparam int TAG_W = 5;
   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_I    = 7'b0010011;
   localparam logic [6:0] OP_LUI  = 7'b0110111;
   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;
   localparam logic [6:0] F7_M    = 7'b0000001;

   logic clk, rst, flush;
   int vectors = 0;
   int miscompares = 0;
   logic [TAG_W-1:0] next_tag = 5'd1;

   integer_execute_unit_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();

   integer_execute_unit #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
      .clk(clk), .rst(rst), .flush(flush), .bus(bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string name, input logic [63:0] observed, input logic [63:0] expected);
      vectors++;
      if (observed !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h, wanted %h", name, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                                input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                                input logic [TAG_W-1:0] tag);
      int w;
      bus.inst_opcode_field              = opc;
      bus.inst_funct3_field              = f3;
      bus.inst_funct7_field              = f7;
      bus.rs1_reg_content                = a;
      bus.rs2_reg_content                = b;
      bus.i_type_integer_inst_imm_extend = imm;
      bus.in_tag                         = tag;
      bus.in_valid                       = 1'b1;
      w = 0;
      while (!bus.in_ready && w < 100) begin
         tick();
         w++;
      end
      checkOutput("in_ready before accept", 64'(bus.in_ready), 64'd1);
      tick();
      bus.in_valid = 1'b0;
   endtask

   task automatic execOp(input string name, input logic [6:0] opc, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] imm, input logic [31:0] exp, input int exp_lat);
      int lat, busy_cycles;
      logic [TAG_W-1:0] tag;
      tag = next_tag;
      next_tag++;
      bus.out_ready = 1'b1;
      applyStimulus(opc, f3, f7, a, b, imm, tag);
      lat = 1;
      busy_cycles = 0;
      while (!bus.out_valid && lat < 200) begin
         if (bus.busy) busy_cycles++;
         tick();
         lat++;
      end
      checkOutput($sformatf("%s result", name), 64'(bus.alu_result), 64'(exp));
      checkOutput($sformatf("%s latency", name), 64'(lat), 64'(exp_lat));
      checkOutput($sformatf("%s busy cycles", name), 64'(busy_cycles), 64'(exp_lat - 1));
      checkOutput($sformatf("%s tag", name), 64'(bus.out_tag), 64'(tag));
      tick();
   endtask

   initial begin
      int seen;
      rst = 1'b1;
      flush = 1'b0;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      bus.rs1_reg_content = '0;
      bus.rs2_reg_content = '0;
      bus.i_type_integer_inst_imm_extend = '0;
      bus.inst_opcode_field = '0;
      bus.inst_funct3_field = '0;
      bus.inst_funct7_field = '0;
      bus.in_tag = '0;
      tick();
      tick();
      rst = 1'b0;
      checkOutput("reset out_valid", 64'(bus.out_valid), 64'd0);
      checkOutput("reset busy", 64'(bus.busy), 64'd0);
      checkOutput("reset in_ready", 64'(bus.in_ready), 64'd1);
      checkOutput("reset alu_result", 64'(bus.alu_result), 64'd0);
      checkOutput("reset out_tag", 64'(bus.out_tag), 64'd0);

      execOp("ADD",    OP_R, 3'b000, F7_BASE, 32'h7FFFFFFF, 32'h1, 32'h0, 32'h80000000, 1);
      execOp("SUB",    OP_R, 3'b000, F7_ALT,  32'd5, 32'd7, 32'h0, 32'hFFFFFFFE, 1);
      execOp("ADDI",   OP_I, 3'b000, F7_ALT,  32'd5, 32'd7, 32'h00000400, 32'h00000405, 1);
      execOp("SRAI",   OP_I, 3'b101, F7_ALT,  32'h80000000, 32'h0, 32'h00000404, 32'hF8000000, 1);
      execOp("SRLI",   OP_I, 3'b101, F7_BASE, 32'h80000000, 32'h0, 32'h00000004, 32'h08000000, 1);
      execOp("SLT",    OP_R, 3'b010, F7_BASE, 32'hFFFFFFFF, 32'h1, 32'h0, 32'h1, 1);
      execOp("SLTU",   OP_R, 3'b011, F7_BASE, 32'hFFFFFFFF, 32'h1, 32'h0, 32'h0, 1);
      execOp("SLL33",  OP_R, 3'b001, F7_BASE, 32'h3, 32'd33, 32'h0, 32'h6, 1);
      execOp("XOR",    OP_R, 3'b100, F7_BASE, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0, 32'h0FF00FF0, 1);
      execOp("ORI",    OP_I, 3'b110, F7_BASE, 32'h00000F00, 32'h0, 32'h000000F0, 32'h00000FF0, 1);
      execOp("AND",    OP_R, 3'b111, F7_BASE, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0, 32'hF000F000, 1);
      execOp("OTHEROP", OP_LUI, 3'b000, F7_BASE, 32'h12345678, 32'h1, 32'h1, 32'h0, 1);

      execOp("MULH",   OP_R, 3'b001, F7_M, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0, 33);
      execOp("MULHU",  OP_R, 3'b011, F7_M, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'hFFFFFFFE, 33);
      execOp("MULHSU", OP_R, 3'b010, F7_M, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF, 33);
      execOp("MUL",    OP_R, 3'b000, F7_M, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h1, 33);
      execOp("MULneg", OP_R, 3'b000, F7_M, 32'hFFFFFFFD, 32'd5, 32'h0, 32'hFFFFFFF1, 33);
      execOp("MULbig", OP_R, 3'b000, F7_M, 32'd12345, 32'd678, 32'h0, 32'h007FB6F6, 33);

      execOp("DIV",    OP_R, 3'b100, F7_M, 32'hFFFFFFF9, 32'd2, 32'h0, 32'hFFFFFFFD, 33);
      execOp("REM",    OP_R, 3'b110, F7_M, 32'hFFFFFFF9, 32'd2, 32'h0, 32'hFFFFFFFF, 33);
      execOp("DIVU",   OP_R, 3'b101, F7_M, 32'd100, 32'd7, 32'h0, 32'd14, 33);
      execOp("REMU",   OP_R, 3'b111, F7_M, 32'd100, 32'd7, 32'h0, 32'd2, 33);
      execOp("DIVU0",  OP_R, 3'b101, F7_M, 32'd7, 32'd0, 32'h0, 32'hFFFFFFFF, 1);
      execOp("REMU0",  OP_R, 3'b111, F7_M, 32'd7, 32'd0, 32'h0, 32'd7, 1);
      execOp("DIVovf", OP_R, 3'b100, F7_M, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1);
      execOp("REMovf", OP_R, 3'b110, F7_M, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h0, 1);

      // Back-pressure: result held while out_ready is low, then back-to-back accept.
      bus.out_ready = 1'b0;
      applyStimulus(OP_R, 3'b000, F7_BASE, 32'd10, 32'd20, 32'h0, 5'd9);
      for (int i = 0; i < 5; i++) begin
         checkOutput($sformatf("hold%0d valid", i), 64'(bus.out_valid), 64'd1);
         checkOutput($sformatf("hold%0d result", i), 64'(bus.alu_result), 64'd30);
         checkOutput($sformatf("hold%0d tag", i), 64'(bus.out_tag), 64'd9);
         checkOutput($sformatf("hold%0d in_ready", i), 64'(bus.in_ready), 64'd0);
         tick();
      end
      bus.out_ready = 1'b1;
      applyStimulus(OP_R, 3'b000, F7_BASE, 32'd1, 32'd2, 32'h0, 5'd10);
      checkOutput("b2b valid", 64'(bus.out_valid), 64'd1);
      checkOutput("b2b result", 64'(bus.alu_result), 64'd3);
      checkOutput("b2b tag", 64'(bus.out_tag), 64'd10);
      tick();
      checkOutput("b2b drained", 64'(bus.out_valid), 64'd0);

      // Flush at cycle 10 of a DIVU: the op must never produce a result.
      applyStimulus(OP_R, 3'b101, F7_M, 32'd1000, 32'd3, 32'h0, 5'd11);
      repeat (9) tick();
      checkOutput("pre-flush busy", 64'(bus.busy), 64'd1);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      checkOutput("flush busy", 64'(bus.busy), 64'd0);
      checkOutput("flush out_valid", 64'(bus.out_valid), 64'd0);
      checkOutput("flush in_ready", 64'(bus.in_ready), 64'd1);
      seen = 0;
      repeat (40) begin
         tick();
         if (bus.out_valid) seen++;
      end
      checkOutput("flush no result", 64'(seen), 64'd0);

      // Flush wins over a same-cycle accept.
      bus.inst_opcode_field = OP_R;
      bus.inst_funct3_field = 3'b000;
      bus.inst_funct7_field = F7_BASE;
      bus.rs1_reg_content = 32'd4;
      bus.rs2_reg_content = 32'd4;
      bus.in_tag = 5'd12;
      bus.in_valid = 1'b1;
      flush = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      flush = 1'b0;
      checkOutput("flush+accept out_valid", 64'(bus.out_valid), 64'd0);
      tick();
      checkOutput("flush+accept stays idle", 64'(bus.out_valid), 64'd0);

      // Reset mid-divide returns every output to its reset value.
      applyStimulus(OP_R, 3'b101, F7_M, 32'd1000, 32'd3, 32'h0, 5'd13);
      repeat (9) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checkOutput("rst busy", 64'(bus.busy), 64'd0);
      checkOutput("rst out_valid", 64'(bus.out_valid), 64'd0);
      checkOutput("rst in_ready", 64'(bus.in_ready), 64'd1);
      checkOutput("rst alu_result", 64'(bus.alu_result), 64'd0);
      checkOutput("rst out_tag", 64'(bus.out_tag), 64'd0);
      seen = 0;
      repeat (40) begin
         tick();
         if (bus.out_valid) seen++;
      end
      checkOutput("rst no result", 64'(seen), 64'd0);

      execOp("post-rst ADD", OP_R, 3'b000, F7_BASE, 32'd40, 32'd2, 32'h0, 32'd42, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
